// File: rtl/qm_memory_if.sv
// qm_memory data-memory bus: word access with req/ack handshake.
// Master drives the request; slave completes it with dm_Ack.
interface qm_memory_if;
    logic [31:0] dm_Addr;
    logic [31:0] dm_WData;
    logic        dm_Write;
    logic        dm_Req;
    logic        dm_Ack;
    logic [31:0] dm_RData;

    modport master (
        output dm_Addr,
        output dm_WData,
        output dm_Write,
        output dm_Req,
        input  dm_Ack,
        input  dm_RData
    );

    modport slave (
        input  dm_Addr,
        input  dm_WData,
        input  dm_Write,
        input  dm_Req,
        output dm_Ack,
        output dm_RData
    );
endinterface

// File: rtl/qm_memory.sv
// qm_memory: MEM stage. EX/MEM register, req/ack word loads and stores,
// upstream stall while the bus is busy, MEM/WB register for writeback.
module qm_memory #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [31:0]      di_ALUOut,
    input  logic [31:0]      di_WriteData,
    input  logic [4:0]       di_WriteReg,
    input  logic             ci_Valid,
    input  logic             ci_RegWrite,
    input  logic             ci_RegWSource,
    input  logic             ci_MemWrite,
    output logic             co_Stall,
    output logic             co_BusError,
    qm_memory_if.master      dm,
    output logic [31:0]      do_ALUOut,
    output logic [31:0]      do_ReadData,
    output logic [4:0]       do_WriteReg,
    output logic             co_Valid,
    output logic             co_RegWrite,
    output logic             co_RegWSource
);

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        reg_wsource;
        logic        mem_write;
        logic [4:0]  write_reg;
        logic [31:0] alu_out;
        logic [31:0] write_data;
    } ex_mem_t;

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_FAULT
    } state_t;

    localparam logic [15:0] TO = 16'(TIMEOUT);

    ex_mem_t     r;
    ex_mem_t     r_in;
    state_t      state;
    state_t      state_n;
    logic [15:0] count;
    logic [15:0] count_n;
    logic        mem_op;
    logic        is_load;
    logic        req;
    logic        stall;

    // Pack the EX-side inputs into one bundle for the EX/MEM register.
    always_comb begin
        r_in             = '0;
        r_in.valid       = ci_Valid;
        r_in.reg_write   = ci_RegWrite;
        r_in.reg_wsource = ci_RegWSource;
        r_in.mem_write   = ci_MemWrite;
        r_in.write_reg   = di_WriteReg;
        r_in.alu_out     = di_ALUOut;
        r_in.write_data  = di_WriteData;
    end

    // Bus request, stall and next-state logic; stall follows dm_Ack combinationally.
    always_comb begin
        state_n = state;
        count_n = count;
        mem_op  = r.valid & (r.mem_write | r.reg_wsource);
        is_load = r.valid & r.reg_wsource & ~r.mem_write;
        req     = mem_op & (state != S_FAULT);
        stall   = (req & ~dm.dm_Ack) | (state == S_FAULT);
        unique case (state)
            S_RUN: begin
                if (mem_op && !dm.dm_Ack) begin
                    state_n = S_WAIT;
                    count_n = 16'd1;
                end
            end
            S_WAIT: begin
                if (dm.dm_Ack) begin
                    state_n = S_RUN;
                    count_n = 16'd0;
                end else begin
                    count_n = count + 16'd1;
                    if (TO != 16'd0 && count == TO) begin
                        state_n = S_FAULT;
                    end
                end
            end
            S_FAULT: begin
                state_n = S_FAULT;
            end
            default: begin
                state_n = S_RUN;
                count_n = 16'd0;
            end
        endcase
    end

    // FSM state and wait counter.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= S_RUN;
            count <= 16'd0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    // EX/MEM register holds while the stage is stalled.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r <= '0;
        end else if (!stall) begin
            r <= r_in;
        end
    end

    // MEM/WB register; a stall cycle inserts a bubble.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            do_ALUOut     <= '0;
            do_ReadData   <= '0;
            do_WriteReg   <= '0;
            co_Valid      <= 1'b0;
            co_RegWrite   <= 1'b0;
            co_RegWSource <= 1'b0;
        end else if (!stall) begin
            do_ALUOut     <= r.alu_out;
            do_ReadData   <= is_load ? dm.dm_RData : 32'd0;
            do_WriteReg   <= r.write_reg;
            co_Valid      <= r.valid;
            co_RegWrite   <= r.valid & r.reg_write;
            co_RegWSource <= r.reg_wsource;
        end else begin
            co_Valid      <= 1'b0;
            co_RegWrite   <= 1'b0;
        end
    end

    assign dm.dm_Addr   = {r.alu_out[31:2], 2'b00};
    assign dm.dm_WData  = r.write_data;
    assign dm.dm_Write  = r.mem_write;
    assign dm.dm_Req    = req;
    assign co_Stall     = stall;
    assign co_BusError  = (state == S_FAULT);

endmodule

// File: tb/tb_qm_memory.sv
// tb_qm_memory: random instruction stream against a transaction-level
// model of the MEM stage, plus directed fault and reset-in-wait cases.
module tb_qm_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] di_ALUOut;
    logic [31:0] di_WriteData;
    logic [4:0]  di_WriteReg;
    logic        ci_Valid;
    logic        ci_RegWrite;
    logic        ci_RegWSource;
    logic        ci_MemWrite;
    logic        co_Stall;
    logic        co_BusError;
    logic [31:0] do_ALUOut;
    logic [31:0] do_ReadData;
    logic [4:0]  do_WriteReg;
    logic        co_Valid;
    logic        co_RegWrite;
    logic        co_RegWSource;

    qm_memory_if dm ();

    qm_memory #(.TIMEOUT(4)) dut (
        .sys_clk       (clk),
        .sys_rst       (rst),
        .di_ALUOut     (di_ALUOut),
        .di_WriteData  (di_WriteData),
        .di_WriteReg   (di_WriteReg),
        .ci_Valid      (ci_Valid),
        .ci_RegWrite   (ci_RegWrite),
        .ci_RegWSource (ci_RegWSource),
        .ci_MemWrite   (ci_MemWrite),
        .co_Stall      (co_Stall),
        .co_BusError   (co_BusError),
        .dm            (dm.master),
        .do_ALUOut     (do_ALUOut),
        .do_ReadData   (do_ReadData),
        .do_WriteReg   (do_WriteReg),
        .co_Valid      (co_Valid),
        .co_RegWrite   (co_RegWrite),
        .co_RegWSource (co_RegWSource)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        valid;
        bit        rw;
        bit        src;
        bit        mw;
        bit [4:0]  wr;
        bit [31:0] alu;
        bit [31:0] wd;
        int        delay;
    } ins_t;

    typedef struct {
        bit [31:0] alu;
        bit [31:0] rd;
        bit [4:0]  wr;
        bit        rw;
        bit        src;
    } wb_t;

    typedef struct {
        bit [31:0] addr;
        bit [31:0] wd;
        bit        wr;
        int        delay;
    } bus_t;

    int tests = 0;
    int fails = 0;

    bit [31:0] mmem [bit [29:0]];
    bit [31:0] bmem [bit [29:0]];
    wb_t       wb_q [$];
    bus_t      bus_q [$];
    int        n_gen = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] pat(bit [29:0] a);
        return {a, 2'b01} ^ 32'hC3A5_0F1E;
    endfunction

    function automatic bit [31:0] m_read(bit [29:0] a);
        return mmem.exists(a) ? mmem[a] : pat(a);
    endfunction

    function automatic bit [31:0] b_read(bit [29:0] a);
        return bmem.exists(a) ? bmem[a] : pat(a);
    endfunction

    task automatic drive(ins_t i);
        ci_Valid      = i.valid;
        ci_RegWrite   = i.rw;
        ci_RegWSource = i.src;
        ci_MemWrite   = i.mw;
        di_WriteReg   = i.wr;
        di_ALUOut     = i.alu;
        di_WriteData  = i.wd;
    endtask

    task automatic gen(output ins_t i);
        int k;
        i = '{default: 0};
        case (n_gen)
            0: i = '{1, 1, 1, 0, 5'd3, 32'h100, 32'h0, 0};
            1: i = '{1, 0, 0, 1, 5'd0, 32'h200, 32'h1234_5678, 3};
            2: i = '{1, 1, 0, 0, 5'd5, 32'd42, 32'h0, 0};
            3: i = '{1, 1, 1, 0, 5'd7, 32'h103, 32'h0, 1};
            4: i = '{1, 1, 1, 0, 5'd8, 32'h200, 32'h0, 4};
            default: begin
                k = $urandom_range(0, 6);
                i.valid = (k != 0);
                i.wr    = 5'($urandom);
                i.wd    = $urandom;
                i.alu   = 32'h1000 + 32'($urandom_range(0, 15) * 4)
                        + 32'($urandom_range(0, 3));
                i.delay = $urandom_range(0, 4);
                if (k == 1 || k == 2) begin
                    i.rw  = 1;
                    i.alu = $urandom;
                end else if (k == 3 || k == 4) begin
                    i.rw  = 1;
                    i.src = 1;
                end else if (k == 5) begin
                    i.mw = 1;
                end else if (k == 6) begin
                    i.mw  = 1;
                    i.src = 1;
                    i.rw  = 1;
                end
            end
        endcase
        n_gen++;
    endtask

    task automatic accept(ins_t i);
        wb_t  w;
        bus_t b;
        bit   mop;
        bit   ld;
        if (!i.valid) return;
        mop = i.mw | i.src;
        ld  = i.src & ~i.mw;
        w.alu = i.alu;
        w.wr  = i.wr;
        w.rw  = i.rw;
        w.src = i.src;
        w.rd  = ld ? m_read(i.alu[31:2]) : 32'd0;
        if (i.mw) mmem[i.alu[31:2]] = i.wd;
        wb_q.push_back(w);
        if (mop) begin
            b.addr  = {i.alu[31:2], 2'b00};
            b.wd    = i.wd;
            b.wr    = i.mw;
            b.delay = i.delay;
            bus_q.push_back(b);
        end
    endtask

    task automatic check_wb(bit prev_stall);
        wb_t w;
        if (prev_stall) check("bubble_valid", co_Valid, 0);
        if (co_Valid) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected", 1, 0);
            end else begin
                w = wb_q.pop_front();
                check("wb_alu", do_ALUOut, w.alu);
                check("wb_rdata", do_ReadData, w.rd);
                check("wb_reg", 32'(do_WriteReg), 32'(w.wr));
                check("wb_rw", 32'(co_RegWrite), 32'(w.rw));
                check("wb_src", 32'(co_RegWSource), 32'(w.src));
            end
        end else begin
            check("bubble_rw", co_RegWrite, 0);
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_valid"}, co_Valid, 0);
        check({tag, "_rw"}, co_RegWrite, 0);
        check({tag, "_src"}, co_RegWSource, 0);
        check({tag, "_alu"}, do_ALUOut, 0);
        check({tag, "_rd"}, do_ReadData, 0);
        check({tag, "_wreg"}, 32'(do_WriteReg), 0);
        check({tag, "_stall"}, co_Stall, 0);
        check({tag, "_berr"}, co_BusError, 0);
        check({tag, "_req"}, dm.dm_Req, 0);
        check({tag, "_addr"}, dm.dm_Addr, 0);
        check({tag, "_wdata"}, dm.dm_WData, 0);
        check({tag, "_write"}, dm.dm_Write, 0);
    endtask

    ins_t cur;
    ins_t bub;
    bit   ack;
    bit   stall;
    bit   acc;
    bit   prev_stall;
    int   waited;
    int   nreq;
    bus_t hd;

    initial begin
        bub = '{default: 0};
        rst = 1'b1;
        drive(bub);
        dm.dm_Ack   = 1'b0;
        dm.dm_RData = 32'h0;
        mmem[30'h40] = 32'hDEAD_BEEF;
        bmem[30'h40] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        gen(cur);
        drive(cur);
        prev_stall = 0;
        waited = 0;

        for (int c = 0; c < 1500; c++) begin
            check("dm_req", dm.dm_Req, 32'(bus_q.size() != 0));
            ack = 0;
            if (bus_q.size() != 0) begin
                hd = bus_q[0];
                check("bus_addr", dm.dm_Addr, hd.addr);
                check("bus_wdata", dm.dm_WData, hd.wd);
                check("bus_write", dm.dm_Write, hd.wr);
                ack = (waited == hd.delay);
                dm.dm_RData = (ack && !hd.wr) ? b_read(hd.addr[31:2])
                                              : $urandom;
            end else begin
                ack = ($urandom_range(0, 3) == 0);
                dm.dm_RData = $urandom;
            end
            dm.dm_Ack = ack;
            #1;
            stall = co_Stall;
            check("stall", stall,
                  32'((bus_q.size() != 0) && !ack));
            if (bus_q.size() != 0) begin
                if (ack) begin
                    hd = bus_q.pop_front();
                    if (hd.wr) bmem[hd.addr[31:2]] = hd.wd;
                    check("stall_len", waited, hd.delay);
                    waited = 0;
                end else begin
                    waited++;
                end
            end
            acc = !stall;
            if (acc) accept(cur);
            @(posedge clk);
            #1;
            dm.dm_Ack = 1'b0;
            if (acc) begin
                if (c > 1400) cur = bub;
                else gen(cur);
                drive(cur);
            end
            check_wb(stall);
            prev_stall = stall;
        end
        check("drain_wb", wb_q.size(), 0);
        check("drain_bus", bus_q.size(), 0);

        // reset while waiting on the bus abandons the access
        cur = '{1, 1, 1, 0, 5'd9, 32'h300, 32'h0, 0};
        drive(cur);
        @(posedge clk);
        #1;
        drive(bub);
        check("rw_req0", dm.dm_Req, 1);
        check("rw_stall0", co_Stall, 1);
        @(posedge clk);
        #1;
        check("rw_req1", dm.dm_Req, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rw_req", dm.dm_Req, 0);
        check("rw_stall", co_Stall, 0);
        check("rw_valid", co_Valid, 0);
        check("rw_berr", co_BusError, 0);
        @(posedge clk);
        #1;
        check("rw_run", co_Stall, 0);

        // timeout: 1 RUN request cycle plus 4 WAIT cycles, then FAULT
        cur = '{1, 1, 1, 0, 5'd4, 32'h400, 32'h0, 0};
        drive(cur);
        nreq = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            drive(bub);
            if (co_BusError) break;
            if (dm.dm_Req) nreq++;
        end
        check("to_reached", co_BusError, 1);
        check("to_req_cycles", nreq, 5);
        for (int c = 0; c < 3; c++) begin
            dm.dm_Ack = c[0];
            #1;
            check("fault_berr", co_BusError, 1);
            check("fault_req", dm.dm_Req, 0);
            check("fault_stall", co_Stall, 1);
            @(posedge clk);
            #1;
            check("fault_valid", co_Valid, 0);
        end
        dm.dm_Ack = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("post_fault");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
